// File: rtl/atm_cell_rewriter.sv
// -----------------------------------------------------------------------------
// atm_cell_rewriter
// Byte-serial ATM cell rewriter. Buffers one 53-byte cell from the receive
// side, checks its HEC, maps the VPI through a configuration table, rewrites
// the header to NNI format with the new VPI and a regenerated HEC, then
// forwards the cell with a per-cell forward mask. Bad cells are dropped and
// counted.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   input byte stream, in_sop marks byte 0
//   nni_mode                    input header format (0=UNI, 1=NNI), taken with byte 0
//   out_valid/out_ready/out_data output byte stream, out_sop/out_eop frame the cell
//   out_fwd                     forward mask for the cell being emitted
//   cfg_we/cfg_addr/cfg_fwd/cfg_vpi  table write port
//   hec_err_cnt, drop_cnt, cell_cnt  saturating statistics
// -----------------------------------------------------------------------------
module atm_cell_rewriter #(
    parameter int NUM_TX = 4,
    parameter int LUT_AW = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_sop,
    input  logic              nni_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [NUM_TX-1:0] out_fwd,
    input  logic              cfg_we,
    input  logic [LUT_AW-1:0] cfg_addr,
    input  logic [NUM_TX-1:0] cfg_fwd,
    input  logic [11:0]       cfg_vpi,
    output logic [CNT_W-1:0]  hec_err_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  cell_cnt
);

    typedef enum logic [1:0] {HUNT, RX, LOOKUP, EMIT} state_t;

    localparam int          LUT_DEPTH = 1 << LUT_AW;
    localparam logic [5:0]  LAST      = 6'd52;

    state_t state, state_n;

    logic [7:0]        cell_buf [53];
    logic [5:0]        idx;
    logic              nni_q;
    logic [NUM_TX-1:0] lut_fwd [LUT_DEPTH];
    logic [11:0]       lut_vpi [LUT_DEPTH];
    logic [NUM_TX-1:0] rd_fwd;
    logic [11:0]       rd_vpi;
    logic [NUM_TX-1:0] fwd_q;
    logic [CNT_W-1:0]  hec_err_q, drop_q, cell_q;

    logic [11:0]       vpi12;
    logic [LUT_AW-1:0] lut_idx;
    logic              vpi_high;
    logic              hec_bad;
    logic              miss;
    logic [7:0]        new_b0, new_b1, new_hec;

    // CRC-8, polynomial x^8+x^2+x+1, MSB first, followed by the 0x55 coset.
    function automatic logic [7:0] hec_of(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0]  c;
        logic [31:0] hdr;
        c   = '0;
        hdr = {b0, b1, b2, b3};
        for (int unsigned i = 0; i < 32; i++) begin
            c = (c[7] ^ hdr[31-i]) ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c ^ 8'h55;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign vpi12    = nni_q ? {cell_buf[0], cell_buf[1][7:4]}
                            : {4'h0, cell_buf[0][3:0], cell_buf[1][7:4]};
    assign lut_idx  = LUT_AW'(vpi12);
    assign vpi_high = nni_q && ((32'(vpi12) >> LUT_AW) != 0);
    assign hec_bad  = hec_of(cell_buf[0], cell_buf[1], cell_buf[2], cell_buf[3]) != cell_buf[4];
    assign miss     = (rd_fwd == '0) || vpi_high;
    // UNI and NNI rewrite to the same bytes: the 12-bit VPI field fully
    // covers byte 0 plus the top nibble of byte 1 (UNI GFC is overwritten).
    assign new_b0   = rd_vpi[11:4];
    assign new_b1   = {rd_vpi[3:0], cell_buf[1][3:0]};
    assign new_hec  = hec_of(new_b0, new_b1, cell_buf[2], cell_buf[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        case (state)
            HUNT: begin
                in_ready = 1'b1;
                if (in_valid && in_sop) state_n = RX;
            end
            RX: begin
                in_ready = 1'b1;
                if (in_valid && !in_sop && idx == LAST) state_n = LOOKUP;
            end
            LOOKUP: begin
                state_n = (hec_bad || miss) ? HUNT : EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = cell_buf[idx];
                out_sop   = (idx == 6'd0);
                out_eop   = (idx == LAST);
                if (out_ready && idx == LAST) state_n = HUNT;
            end
            default: state_n = HUNT;
        endcase
    end

    // Cell storage carries no reset: contents are only observed in EMIT,
    // which is reached only after a full cell has been written.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready && (in_sop || state == RX)) begin
            cell_buf[in_sop ? 6'd0 : idx] <= in_data;
        end
        if (state == LOOKUP && !hec_bad && !miss) begin
            cell_buf[0] <= new_b0;
            cell_buf[1] <= new_b1;
            cell_buf[4] <= new_hec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            nni_q     <= 1'b0;
            rd_fwd    <= '0;
            rd_vpi    <= '0;
            fwd_q     <= '0;
            hec_err_q <= '0;
            drop_q    <= '0;
            cell_q    <= '0;
            for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
                lut_fwd[i] <= '0;
                lut_vpi[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                lut_fwd[cfg_addr] <= cfg_fwd;
                lut_vpi[cfg_addr] <= cfg_vpi;
            end
            case (state)
                HUNT: begin
                    if (in_valid && in_sop) begin
                        idx   <= 6'd1;
                        nni_q <= nni_mode;
                    end
                end
                RX: begin
                    if (in_valid) begin
                        if (in_sop) begin
                            drop_q <= sat_inc(drop_q);
                            idx    <= 6'd1;
                            nni_q  <= nni_mode;
                        end else if (idx == LAST) begin
                            // Table read is taken with the last byte, so a
                            // write during LOOKUP cannot affect this cell.
                            rd_fwd <= lut_fwd[lut_idx];
                            rd_vpi <= lut_vpi[lut_idx];
                            idx    <= '0;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                LOOKUP: begin
                    if (hec_bad)   hec_err_q <= sat_inc(hec_err_q);
                    else if (miss) drop_q    <= sat_inc(drop_q);
                    else           fwd_q     <= rd_fwd;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (idx == LAST) begin
                            cell_q <= sat_inc(cell_q);
                            idx    <= '0;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_fwd     = fwd_q;
    assign hec_err_cnt = hec_err_q;
    assign drop_cnt    = drop_q;
    assign cell_cnt    = cell_q;

endmodule

// File: tb/tb_atm_cell_rewriter.sv
// -----------------------------------------------------------------------------
// tb_atm_cell_rewriter
// Self-checking bench: directed cells from the test plan followed by random
// cells, all compared against a queue-based reference model. CNT_W is reduced
// so counter saturation is reached by the random phase.
// -----------------------------------------------------------------------------
module tb_atm_cell_rewriter;

    localparam int NUM_TX = 4;
    localparam int LUT_AW = 8;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_sop, nni_mode;
    logic [7:0]        in_data;
    logic              out_valid, out_ready, out_sop, out_eop;
    logic [7:0]        out_data;
    logic [NUM_TX-1:0] out_fwd;
    logic              cfg_we;
    logic [LUT_AW-1:0] cfg_addr;
    logic [NUM_TX-1:0] cfg_fwd;
    logic [11:0]       cfg_vpi;
    logic [CNT_W-1:0]  hec_err_cnt, drop_cnt, cell_cnt;

    atm_cell_rewriter #(.NUM_TX(NUM_TX), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .nni_mode(nni_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_fwd(out_fwd),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_fwd(cfg_fwd), .cfg_vpi(cfg_vpi),
        .hec_err_cnt(hec_err_cnt), .drop_cnt(drop_cnt), .cell_cnt(cell_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NUM_TX-1:0] m_fwd [256];
    logic [11:0]       m_vpi [256];
    int                m_hec, m_drop, m_cell;
    logic [7:0]        exp_bytes[$];
    logic [NUM_TX-1:0] exp_fwd[$];
    bit                lat_pend;
    int                last_hs;
    bit                runt_pend;

    logic [7:0]        tx_cell [53];
    bit                gap_en;
    int                rdy_mode;

    // Remainder of hdr(x)*x^8 modulo x^8+x^2+x+1, then the 0x55 coset.
    function automatic logic [7:0] m_hec_of(input logic [31:0] hdr);
        logic [39:0] r;
        r = {hdr, 8'h00};
        for (int i = 39; i >= 8; i--)
            if (r[i]) r = r ^ (40'h107 << (i - 8));
        return r[7:0] ^ 8'h55;
    endfunction

    function automatic int m_sat(input int v);
        return (v >= CMAX) ? v : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_fwd[i] = '0;
            m_vpi[i] = '0;
        end
        m_hec = 0; m_drop = 0; m_cell = 0;
        exp_bytes.delete();
        exp_fwd.delete();
        lat_pend  = 0;
        runt_pend = 0;
    endtask

    task automatic model_cell(input bit nni, input int hs);
        logic [11:0] vpi;
        logic [11:0] nv;
        logic [7:0]  b0, b1;
        vpi = nni ? {tx_cell[0], tx_cell[1][7:4]} : {4'h0, tx_cell[0][3:0], tx_cell[1][7:4]};
        if (m_hec_of({tx_cell[0], tx_cell[1], tx_cell[2], tx_cell[3]}) != tx_cell[4]) begin
            m_hec = m_sat(m_hec);
        end else if (vpi > 12'd255 || m_fwd[vpi[7:0]] == '0) begin
            m_drop = m_sat(m_drop);
        end else begin
            nv = m_vpi[vpi[7:0]];
            b0 = nv[11:4];
            b1 = {nv[3:0], tx_cell[1][3:0]};
            exp_bytes.push_back(b0);
            exp_bytes.push_back(b1);
            exp_bytes.push_back(tx_cell[2]);
            exp_bytes.push_back(tx_cell[3]);
            exp_bytes.push_back(m_hec_of({b0, b1, tx_cell[2], tx_cell[3]}));
            for (int i = 5; i < 53; i++) exp_bytes.push_back(tx_cell[i]);
            exp_fwd.push_back(m_fwd[vpi[7:0]]);
            m_cell   = m_sat(m_cell);
            last_hs  = hs;
            lat_pend = 1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cfg_write(input int addr, input logic [NUM_TX-1:0] f, input logic [11:0] v);
        cfg_we   = 1'b1;
        cfg_addr = LUT_AW'(addr);
        cfg_fwd  = f;
        cfg_vpi  = v;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_fwd[addr] = f;
        m_vpi[addr] = v;
    endtask

    task automatic set_header(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        tx_cell[0] = b0; tx_cell[1] = b1; tx_cell[2] = b2; tx_cell[3] = b3; tx_cell[4] = b4;
        for (int i = 5; i < 53; i++) tx_cell[i] = 8'(i - 5);
    endtask

    // n < 53 sends a runt; it is charged when the next cell's byte 0 arrives.
    task automatic send_cell(input int n, input bit nni);
        int hs;
        hs = 0;
        if (runt_pend) begin
            m_drop    = m_sat(m_drop);
            runt_pend = 0;
        end
        for (int i = 0; i < n; i++) begin
            if (gap_en && ($urandom % 4 == 0)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_sop   = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = tx_cell[i];
            in_sop   = (i == 0);
            nni_mode = (i == 0) ? nni : 1'($urandom);
            hs = cyc;
            if (i == 0) check_val("in_ready_sop", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        if (n < 53) runt_pend = 1;
        else        model_cell(nni, hs);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (exp_bytes.size() == 0 && !out_valid && in_ready) done = 1;
        end
        if (!done) check_val({tag, "_idle_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_counters(input string tag);
        check_val({tag, "_hec_err_cnt"}, hec_err_cnt, m_hec);
        check_val({tag, "_drop_cnt"},    drop_cnt,    m_drop);
        check_val({tag, "_cell_cnt"},    cell_cnt,    m_cell);
    endtask

    // ---------------- output ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom);
            endcase
        end
    end

    // ---------------- output monitor ----------------
    int         got_n = 0;
    bit         hold_pend = 0;
    bit         prev_valid = 0;
    logic [7:0] h_data;
    logic       h_sop, h_eop;

    always @(negedge clk) begin
        if (!rst_n) begin
            got_n      = 0;
            hold_pend  = 0;
            prev_valid = 0;
        end else begin
            if (hold_pend) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_data",  out_data,  h_data);
                check_val("hold_sop",   out_sop,   h_sop);
                check_val("hold_eop",   out_eop,   h_eop);
                hold_pend = 0;
            end
            if (out_valid && !prev_valid) begin
                check_val("out_expected", lat_pend, 1);
                if (lat_pend) check_val("latency", cyc - last_hs, 2);
                lat_pend = 0;
            end
            if (out_valid) begin
                if (out_ready) begin
                    check_val("byte_available", exp_bytes.size() > 0, 1);
                    if (exp_bytes.size() > 0) begin
                        check_val($sformatf("data_b%0d", got_n), out_data, exp_bytes.pop_front());
                        check_val("sop", out_sop, got_n == 0);
                        check_val("eop", out_eop, got_n == 52);
                        if (exp_fwd.size() > 0) check_val("fwd", out_fwd, exp_fwd[0]);
                        got_n++;
                        if (got_n == 53) begin
                            got_n = 0;
                            if (exp_fwd.size() > 0) void'(exp_fwd.pop_front());
                        end
                    end
                end else begin
                    hold_pend = 1;
                    h_data    = out_data;
                    h_sop     = out_sop;
                    h_eop     = out_eop;
                end
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [11:0] vpi;
        logic [7:0]  b0, b1, b2, b3, b4;
        bit          nni;
        bit          hit;

        rst_n = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_data = '0; nni_mode = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_fwd = '0; cfg_vpi = '0;
        gap_en = 0; rdy_mode = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready",  in_ready,  1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_sop",   out_sop,   0);
        check_val("rst_out_eop",   out_eop,   0);
        check_val("rst_out_data",  out_data,  0);
        check_val("rst_out_fwd",   out_fwd,   0);
        check_counters("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Passthrough
        cfg_write(0, 4'b0101, 12'h000);
        set_header(8'h00, 8'h00, 8'h00, 8'h00, 8'h55);
        send_cell(53, 0);
        wait_idle("pass");
        check_counters("pass");

        // VPI rewrite
        cfg_write(0, 4'b1000, 12'hABC);
        set_header(8'h00, 8'h00, 8'h00, 8'h01, 8'h52);
        send_cell(53, 0);
        wait_idle("rewrite");
        check_counters("rewrite");

        // HEC error, then a good cell
        set_header(8'h00, 8'h00, 8'h00, 8'h00, 8'h56);
        send_cell(53, 0);
        wait_idle("hec");
        check_val("hec_err_cnt_is_1", hec_err_cnt, 1);
        set_header(8'h00, 8'h00, 8'h00, 8'h00, 8'h55);
        send_cell(53, 0);
        wait_idle("after_hec");
        check_counters("after_hec");

        // Unmapped UNI VPI=5, then NNI VPI=0x100 (aliases mapped index 0)
        set_header(8'h00, 8'h50, 8'h00, 8'h00, m_hec_of(32'h0050_0000));
        send_cell(53, 0);
        wait_idle("unmap_uni");
        check_val("drop_cnt_is_1", drop_cnt, 1);
        set_header(8'h10, 8'h00, 8'h00, 8'h00, m_hec_of(32'h1000_0000));
        send_cell(53, 1);
        wait_idle("unmap_nni");
        check_val("drop_cnt_is_2", drop_cnt, 2);
        check_counters("unmap");

        // Runt then full cell with toggling backpressure
        rdy_mode = 1;
        set_header(8'h00, 8'h00, 8'h00, 8'h00, 8'h55);
        send_cell(20, 0);
        send_cell(53, 0);
        wait_idle("runt");
        check_val("drop_cnt_is_3", drop_cnt, 3);
        check_counters("runt");

        // Random cells
        gap_en   = 1;
        rdy_mode = 2;
        for (int a = 0; a < 8; a++) cfg_write(a, 4'($urandom), 12'($urandom));
        for (int c = 0; c < 60; c++) begin
            if ($urandom % 6 == 0) cfg_write($urandom_range(0, 7), 4'($urandom), 12'($urandom));
            nni = 1'($urandom);
            vpi = ($urandom % 5 == 0) ? 12'($urandom) : 12'($urandom_range(0, 7));
            if (nni) begin
                b0 = vpi[11:4];
                b1 = {vpi[3:0], 4'($urandom)};
            end else begin
                b0 = {4'($urandom), vpi[7:4]};
                b1 = {vpi[3:0], 4'($urandom)};
            end
            b2 = 8'($urandom);
            b3 = 8'($urandom);
            b4 = m_hec_of({b0, b1, b2, b3});
            if ($urandom % 4 == 0) b4 = b4 ^ 8'($urandom_range(1, 255));
            tx_cell[0] = b0; tx_cell[1] = b1; tx_cell[2] = b2; tx_cell[3] = b3; tx_cell[4] = b4;
            for (int i = 5; i < 53; i++) tx_cell[i] = 8'($urandom);
            send_cell(($urandom % 8 == 0) ? int'($urandom_range(1, 52)) : 53, nni);
            wait_idle("rand");
            check_counters("rand");
        end

        // Reset in the middle of an emitted cell
        gap_en   = 0;
        rdy_mode = 0;
        cfg_write(0, 4'b0101, 12'h000);
        set_header(8'h00, 8'h00, 8'h00, 8'h00, 8'h55);
        send_cell(53, 0);
        hit = 0;
        for (int k = 0; k < 500 && !hit; k++) begin
            @(negedge clk); #1;
            if (got_n >= 30) hit = 1;
        end
        check_val("reach_byte30", hit, 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_out_data",  out_data,  0);
        check_val("midrst_out_fwd",   out_fwd,   0);
        model_reset();
        check_counters("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        // Table was cleared by reset, so this cell must drop.
        set_header(8'h00, 8'h00, 8'h00, 8'h00, 8'h55);
        send_cell(53, 0);
        wait_idle("post_rst");
        check_counters("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
